// File: rtl/upcounter_sync_pkg.sv
// Shared definitions for the up-counter: default geometry and the per-edge operation encoding.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package upcounter_sync_pkg;

    // Default geometry, kept identical to the down-counter defaults.
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_MODULO = 16;

    // Operation selected at an edge, in priority order clear > load > increment > hold.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_INC   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    // Resolve the control inputs to the single operation that takes effect.
    function automatic op_e op_sel(input logic clr, input logic ld, input logic en);
        op_e op;
        if (clr) begin
            op = OP_CLEAR;
        end else if (ld) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_INC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/upcounter_sync.sv
// Modulo-N up-counter with clear/load/enable, wrap or saturate, terminal pulse, sticky overflow, compare match.
// Latency: all outputs registered; q, tc, ovf and match update one edge after the controls are applied.
// Backpressure: none; the counter accepts clr/ld/en on every edge, en is the only flow control.
module upcounter_sync
    import upcounter_sync_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULO   = DEF_MODULO,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             match
);

    // Refuse to elaborate with a count range that does not fit the counter width.
    generate
        if (WIDTH < 1 || MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_params
            $error("upcounter_sync: MODULO must be in 2..2**WIDTH and WIDTH >= 1");
        end
    endgenerate

    // Terminal count value; for MODULO == 2**WIDTH this is all-ones and wrap is natural rollover.
    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             match_q, match_d;
    op_e              op;
    logic             at_term;
    logic             term_evt;

    // Next-state for every register, derived from the single resolved operation.
    always_comb begin
        op       = op_sel(clr, ld, en);
        at_term  = (q_q == TERM);
        term_evt = (op == OP_INC) && at_term;
        q_d      = q_q;
        case (op)
            OP_CLEAR: q_d = '0;
            OP_LOAD:  q_d = (ld_val > TERM) ? TERM : ld_val;
            OP_INC: begin
                if (!at_term) begin
                    q_d = q_q + ONE;
                end else if (SATURATE != 0) begin
                    q_d = q_q;
                end else begin
                    q_d = '0;
                end
            end
            default:  q_d = q_q;
        endcase
        tc_d    = term_evt;
        // A terminal event on the same edge as ovf_clr keeps the flag set.
        ovf_d   = term_evt | (ovf_q & ~ovf_clr);
        // Compare against the value q is about to take so match lines up with q.
        match_d = (q_d == cmp_val);
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q     <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

    assign q     = q_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign match = match_q;

endmodule
